// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: sequenced release of NDOM downstream reset domains.
// All domain resets are held for HOLD cycles, then released one at a time
// in ascending index order. Each release waits for the previous domain's
// ready acknowledge. A soft request restarts the whole sequence.
// Optional feature macro: RST_SEQ_TIMEOUT_EN. When it is defined, each
// domain has TMO cycles to acknowledge before the block stops in ERR.
// When it is undefined, the wait for an acknowledge has no limit.
module rst_seq_ctrl #(
    parameter int NDOM = 4,
    parameter int HOLD = 2,
    parameter int TMO  = 15
) (
    input  logic                    clk,
    input  logic                    irst,
    input  logic                    isoft_req,
    input  logic [NDOM-1:0]         iready,
    output logic [NDOM-1:0]         oreset,
    output logic                    odone,
    output logic                    oerr,
    output logic [$clog2(NDOM)-1:0] odom
);

    localparam int DW = $clog2(NDOM);
    localparam logic [7:0]    HOLD_LAST = 8'(HOLD - 1);
    localparam logic [DW-1:0] DOM_LAST  = DW'(NDOM - 1);

    typedef enum logic [1:0] {
        S_HOLD,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    logic [7:0]        r_hold_cnt;
    logic [NDOM-1:0]   r_reset;
    logic              r_done;
    logic [DW-1:0]     r_dom;

    logic              w_ack;
    logic [DW-1:0]     w_next_dom;

`ifdef RST_SEQ_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);
    logic              r_err;
    logic [7:0]        r_wait_cnt;
`endif

    // Only the awaited domain's acknowledge matters; every other ready bit is ignored.
    assign w_ack      = iready[r_dom];
    assign w_next_dom = r_dom + DW'(1);

    // Sequencer FSM. Every output comes straight from a register here.
    // NOTE: the reset branch is asynchronous, so irst forces every domain
    // back into reset at once, without waiting for a clock edge.
    always_ff @(posedge clk or posedge irst) begin
        if (irst) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= 8'd0;
            r_reset    <= '1;
            r_done     <= 1'b0;
            r_dom      <= '0;
`ifdef RST_SEQ_TIMEOUT_EN
            r_err      <= 1'b0;
            r_wait_cnt <= 8'd0;
`endif
        end else if (isoft_req) begin
            // A soft request takes priority over an acknowledge or a timeout
            // on the same edge. While the request is held high the hold
            // count stays at 0.
            r_state    <= S_HOLD;
            r_hold_cnt <= 8'd0;
            r_reset    <= '1;
            r_done     <= 1'b0;
            r_dom      <= '0;
`ifdef RST_SEQ_TIMEOUT_EN
            r_err      <= 1'b0;
`endif
        end else begin
            // NOTE: state is updated with non-blocking assignments, so every
            // condition below tests the values from before this edge.
            case (r_state)
                S_HOLD: begin
                    r_hold_cnt <= r_hold_cnt + 8'd1;
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_reset[0] <= 1'b0;
                        r_dom      <= '0;
                        r_state    <= S_WAIT;
`ifdef RST_SEQ_TIMEOUT_EN
                        r_wait_cnt <= 8'd0;
`endif
                    end
                end

                S_WAIT: begin
                    if (w_ack) begin
                        // An acknowledge on the limit edge still counts as success.
                        if (r_dom == DOM_LAST) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_reset[w_next_dom] <= 1'b0;
                            r_dom               <= w_next_dom;
                        end
`ifdef RST_SEQ_TIMEOUT_EN
                        r_wait_cnt <= 8'd0;
                    end else if (r_wait_cnt == TMO_LAST) begin
                        // r_dom is kept so that it reports the domain that failed.
                        r_state <= S_ERR;
                        r_reset <= '1;
                        r_err   <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
`endif
                    end
                end

                // DONE and ERR persist until irst or isoft_req; iready is ignored here.
                S_DONE: r_state <= S_DONE;
                S_ERR:  r_state <= S_ERR;
                default: r_state <= S_HOLD;
            endcase
        end
    end

    assign oreset = r_reset;
    assign odone  = r_done;
    assign odom   = r_dom;

`ifdef RST_SEQ_TIMEOUT_EN
    assign oerr = r_err;
`else
    // Without the timeout feature no error can be raised.
    assign oerr = 1'b0;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed testbench for rst_seq_ctrl with NDOM=4, HOLD=2, TMO=8.
// Expected values are worked out by hand from the required behaviour.
// The timeout checks are compiled only when RST_SEQ_TIMEOUT_EN is defined.
module tb_rst_seq_ctrl;

    localparam int NDOM = 4;
    localparam int HOLD = 2;
    localparam int TMO  = 8;

    logic            clk;
    logic            irst;
    logic            isoft_req;
    logic [NDOM-1:0] iready;
    logic [NDOM-1:0] oreset;
    logic            odone;
    logic            oerr;
    logic [1:0]      odom;

    int n_checks;
    int n_errors;

    rst_seq_ctrl #(
        .NDOM (NDOM),
        .HOLD (HOLD),
        .TMO  (TMO)
    ) dut (
        .clk       (clk),
        .irst      (irst),
        .isoft_req (isoft_req),
        .iready    (iready),
        .oreset    (oreset),
        .odone     (odone),
        .oerr      (oerr),
        .odom      (odom)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance one rising edge, then let the outputs settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [3:0] rst_v,
                                input logic done_v, input logic err_v, input logic [1:0] dom_v);
        check({tag, ".oreset"}, 32'(oreset), 32'(rst_v));
        check({tag, ".odone"},  32'(odone),  32'(done_v));
        check({tag, ".oerr"},   32'(oerr),   32'(err_v));
        check({tag, ".odom"},   32'(odom),   32'(dom_v));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        irst      = 1'b1;
        isoft_req = 1'b0;
        iready    = 4'b0000;
        #2;
        expect_state("reset", 4'b1111, 1'b0, 1'b0, 2'd0);

        // Full sequence with every domain ready.
        tick();
        irst   = 1'b0;
        iready = 4'b1111;
        tick(); expect_state("seq.e1", 4'b1111, 1'b0, 1'b0, 2'd0);
        tick(); expect_state("seq.e2", 4'b1110, 1'b0, 1'b0, 2'd0);
        tick(); expect_state("seq.e3", 4'b1100, 1'b0, 1'b0, 2'd1);
        tick(); expect_state("seq.e4", 4'b1000, 1'b0, 1'b0, 2'd2);
        tick(); expect_state("seq.e5", 4'b0000, 1'b0, 1'b0, 2'd3);
        tick(); expect_state("seq.e6", 4'b0000, 1'b1, 1'b0, 2'd3);
        iready = 4'b0000;
        tick(); expect_state("done.hold", 4'b0000, 1'b1, 1'b0, 2'd3);

        // Soft request while in DONE restarts the sequence.
        isoft_req = 1'b1;
        tick(); expect_state("soft.done", 4'b1111, 1'b0, 1'b0, 2'd0);
        isoft_req = 1'b0;
        iready    = 4'b1111;
        tick(); expect_state("soft.h1", 4'b1111, 1'b0, 1'b0, 2'd0);
        tick(); expect_state("soft.h2", 4'b1110, 1'b0, 1'b0, 2'd0);

        // Withhold iready[1] for 5 cycles while the other bits stay high.
        iready = 4'b1101;
        tick(); expect_state("stall.rel1", 4'b1100, 1'b0, 1'b0, 2'd1);
        for (int i = 0; i < 5; i++) begin
            tick(); expect_state($sformatf("stall.c%0d", i), 4'b1100, 1'b0, 1'b0, 2'd1);
        end
        iready = 4'b1111;
        tick(); expect_state("stall.rel2", 4'b1000, 1'b0, 1'b0, 2'd2);

        // Soft request on the same edge as an acknowledge: the soft request wins.
        isoft_req = 1'b1;
        tick(); expect_state("soft.ack", 4'b1111, 1'b0, 1'b0, 2'd0);
        // Holding the request keeps the hold counter at 0.
        tick(); expect_state("soft.held1", 4'b1111, 1'b0, 1'b0, 2'd0);
        tick(); expect_state("soft.held2", 4'b1111, 1'b0, 1'b0, 2'd0);
        isoft_req = 1'b0;
        tick(); expect_state("soft.r1", 4'b1111, 1'b0, 1'b0, 2'd0);
        tick(); expect_state("soft.r2", 4'b1110, 1'b0, 1'b0, 2'd0);

        // Ready bits other than iready[odom] must be ignored, even if stuck high.
        iready = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            tick(); expect_state($sformatf("stuck.c%0d", i), 4'b1110, 1'b0, 1'b0, 2'd0);
        end

`ifdef RST_SEQ_TIMEOUT_EN
        // Domain 2 never acknowledges, so the block times out TMO edges after oreset=1000.
        iready = 4'b0011;
        tick(); expect_state("tmo.rel1", 4'b1100, 1'b0, 1'b0, 2'd1);
        tick(); expect_state("tmo.rel2", 4'b1000, 1'b0, 1'b0, 2'd2);
        for (int i = 1; i < TMO; i++) begin
            tick(); expect_state($sformatf("tmo.w%0d", i), 4'b1000, 1'b0, 1'b0, 2'd2);
        end
        tick(); expect_state("tmo.err", 4'b1111, 1'b0, 1'b1, 2'd2);
        iready = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick(); expect_state($sformatf("tmo.stay%0d", i), 4'b1111, 1'b0, 1'b1, 2'd2);
        end
        isoft_req = 1'b1;
        tick(); expect_state("tmo.soft", 4'b1111, 1'b0, 1'b0, 2'd0);
        isoft_req = 1'b0;
        iready    = 4'b0000;
        tick(); expect_state("tmo.h1", 4'b1111, 1'b0, 1'b0, 2'd0);
        tick(); expect_state("tmo.h2", 4'b1110, 1'b0, 1'b0, 2'd0);
        // An acknowledge on the limit edge counts as success.
        for (int i = 1; i < TMO; i++) begin
            tick(); expect_state($sformatf("lim.w%0d", i), 4'b1110, 1'b0, 1'b0, 2'd0);
        end
        iready = 4'b0001;
        tick(); expect_state("lim.ack", 4'b1100, 1'b0, 1'b0, 2'd1);
`else
        // With no timeout, WAIT lasts indefinitely and oerr stays 0.
        iready = 4'b0000;
        for (int i = 0; i < 100; i++) begin
            tick();
            check($sformatf("notmo.rst%0d", i), 32'(oreset), 32'(4'b1110));
            check($sformatf("notmo.err%0d", i), 32'(oerr), 32'd0);
        end
        iready = 4'b1111;
        tick(); expect_state("notmo.rel1", 4'b1100, 1'b0, 1'b0, 2'd1);
`endif

        // irst asserted between edges mid-WAIT must act before the next posedge.
        #2;
        irst = 1'b1;
        #1;
        expect_state("async.rst", 4'b1111, 1'b0, 1'b0, 2'd0);
        tick();
        irst   = 1'b0;
        iready = 4'b1111;
        tick(); expect_state("async.h1", 4'b1111, 1'b0, 1'b0, 2'd0);
        tick(); expect_state("async.h2", 4'b1110, 1'b0, 1'b0, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
